// File: rtl/min_cost_select.sv
// Open-set minimum selector: sweeps the node-cost queue and reports the lowest non-INVALID cost and its address.
// Optional macro CLOSE_ON_SELECT_EN adds a CLOSE state that writes INVALID back to the selected entry.
module min_cost_select #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [DATA_WIDTH-1:0] min_cost,
    output logic [ADDR_WIDTH-1:0] min_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int N     = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] INVALID = '1;
    localparam logic [CNT_W-1:0]      LAST    = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
`ifdef CLOSE_ON_SELECT_EN
        ST_CLOSE,
`endif
        ST_DONE
    } state_t;

    function automatic logic is_open(input logic [DATA_WIDTH-1:0] cost);
        return cost != INVALID;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  found_q, found_d;
    logic [DATA_WIDTH-1:0] min_cost_q, min_cost_d;
    logic [ADDR_WIDTH-1:0] min_addr_q, min_addr_d;
    logic                  vld_p1_q, vld_p1_d;
    logic [ADDR_WIDTH-1:0] addr_p1_q;
    logic [DATA_WIDTH-1:0] run_cost_q, run_cost_d;
    logic [ADDR_WIDTH-1:0] run_addr_q, run_addr_d;
    logic                  run_found_q, run_found_d;
`ifdef CLOSE_ON_SELECT_EN
    logic                  mem_we_q, mem_we_d;
`endif

    // Compare stage: mem_data pairs with addr_p1_q, the address issued one cycle earlier.
    always_comb begin
        run_cost_d  = run_cost_q;
        run_addr_d  = run_addr_q;
        run_found_d = run_found_q;
        if (state_q == ST_IDLE && start) begin
            run_cost_d  = INVALID;
            run_addr_d  = '0;
            run_found_d = 1'b0;
        end else if (vld_p1_q && is_open(mem_data)) begin
            run_found_d = 1'b1;
            if (mem_data < run_cost_q) begin
                run_cost_d = mem_data;
                run_addr_d = addr_p1_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        found_d    = found_q;
        min_cost_d = min_cost_q;
        min_addr_d = min_addr_q;
        vld_p1_d   = (state_q == ST_SCAN);
`ifdef CLOSE_ON_SELECT_EN
        mem_we_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (cnt_q == LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_addr_d = cnt_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                end
            end
`ifdef CLOSE_ON_SELECT_EN
            // Final compare lands this cycle, so the write-back uses the next running values.
            ST_DRAIN: begin
                state_d    = ST_CLOSE;
                mem_we_d   = run_found_d;
                mem_addr_d = run_found_d ? run_addr_d : '0;
            end
            ST_CLOSE: begin
                state_d    = ST_DONE;
                done_d     = 1'b1;
                found_d    = run_found_q;
                min_cost_d = run_cost_q;
                min_addr_d = run_addr_q;
            end
`else
            ST_DRAIN: begin
                state_d    = ST_DONE;
                done_d     = 1'b1;
                found_d    = run_found_d;
                min_cost_d = run_cost_d;
                min_addr_d = run_addr_d;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            min_cost_q <= '0;
            min_addr_q <= '0;
            vld_p1_q   <= 1'b0;
`ifdef CLOSE_ON_SELECT_EN
            mem_we_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
            min_cost_q <= min_cost_d;
            min_addr_q <= min_addr_d;
            vld_p1_q   <= vld_p1_d;
`ifdef CLOSE_ON_SELECT_EN
            mem_we_q   <= mem_we_d;
`endif
        end
    end

    // Datapath registers carry no reset; a scan start always reinitialises them.
    always_ff @(posedge clk) begin
        addr_p1_q   <= mem_addr_q;
        run_cost_q  <= run_cost_d;
        run_addr_q  <= run_addr_d;
        run_found_q <= run_found_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign min_cost  = min_cost_q;
    assign min_addr  = min_addr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = INVALID;
`ifdef CLOSE_ON_SELECT_EN
    assign mem_we    = mem_we_q;
`else
    assign mem_we    = 1'b0;
`endif

endmodule

// File: tb/tb_min_cost_select.sv
// Directed bench for min_cost_select with a one-cycle-latency queue model.
// Also covers the CLOSE_ON_SELECT_EN build when that macro is defined.
module tb_min_cost_select;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;
`ifdef CLOSE_ON_SELECT_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = N + 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, found, mem_we;
    logic [DW-1:0] min_cost, mem_data, mem_wdata;
    logic [AW-1:0] min_addr, mem_addr;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] img [N];
    logic          load = 1'b0;

    int checks = 0;
    int failures = 0;

    min_cost_select #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .found(found), .min_cost(min_cost), .min_addr(min_addr),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    // Queue model: registered read, write port driven by the DUT, bulk load from the bench.
    always @(posedge clk) begin
        if (load) mem <= img;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_img(input int a0, input logic [DW-1:0] v0,
                            input int a1, input logic [DW-1:0] v1,
                            input int a2, input logic [DW-1:0] v2);
        for (int i = 0; i < N; i++) img[i] = 8'hFF;
        if (a0 >= 0) img[a0] = v0;
        if (a1 >= 0) img[a1] = v1;
        if (a2 >= 0) img[a2] = v2;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Called #1 after a rising edge; start is sampled at the next edge (edge 0).
    task automatic run_scan(input int xs_cyc, input int rst_cyc,
                            output int done_cyc, output int n_done,
                            output int we_cyc, output int we_addr,
                            output bit busy_ok, output bit hold_ok);
        logic          p_found;
        logic [DW-1:0] p_cost;
        logic [AW-1:0] p_addr;
        p_found = found; p_cost = min_cost; p_addr = min_addr;
        done_cyc = 0; n_done = 0; we_cyc = 0; we_addr = 0;
        busy_ok = 1'b1; hold_ok = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            start = (c == xs_cyc);
            if (rst_cyc != 0 && c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_found", found, 0);
                chk("rst_cost", min_cost, 0);
                chk("rst_addr", min_addr, 0);
                chk("rst_maddr", mem_addr, 0);
                chk("rst_we", mem_we, 0);
            end
            if (rst_cyc != 0 && c == rst_cyc + 1) rst_n = 1'b1;
            if (rst_cyc == 0) begin
                if (done_cyc == 0 && !busy) busy_ok = 1'b0;
                if (done_cyc != 0 && c == done_cyc + 1 && busy) busy_ok = 1'b0;
                if (done_cyc == 0 && !done &&
                    (found !== p_found || min_cost !== p_cost || min_addr !== p_addr))
                    hold_ok = 1'b0;
            end
            if (mem_we) begin
                we_cyc = c;
                we_addr = int'(mem_addr);
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
        end
        start = 1'b0;
    endtask

    int  dc, nd, wc, wa;
    bit  bok, hok;

    initial begin
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_found", found, 0);
        chk("reset_cost", min_cost, 0);
        chk("reset_addr", min_addr, 0);
        chk("reset_maddr", mem_addr, 0);
        chk("reset_we", mem_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All slots closed
        load_img(-1, 0, -1, 0, -1, 0);
        run_scan(0, 0, dc, nd, wc, wa, bok, hok);
        chk("empty_latency", dc, LAT);
        chk("empty_ndone", nd, 1);
        chk("empty_found", found, 0);
        chk("empty_cost", min_cost, 8'hFF);
        chk("empty_addr", min_addr, 0);
        chk("empty_busy", bok, 1);
        chk("empty_no_write", wc, 0);

        // Two open entries
        load_img(3, 8'h20, 9, 8'h10, -1, 0);
        run_scan(0, 0, dc, nd, wc, wa, bok, hok);
        chk("two_latency", dc, LAT);
        chk("two_found", found, 1);
        chk("two_addr", min_addr, 9);
        chk("two_cost", min_cost, 8'h10);
        chk("two_hold", hok, 1);
`ifdef CLOSE_ON_SELECT_EN
        chk("close_we_cyc", wc, N + 2);
        chk("close_we_addr", wa, 9);
        chk("close_mem9", mem[9], 8'hFF);
        run_scan(0, 0, dc, nd, wc, wa, bok, hok);
        chk("close2_addr", min_addr, 3);
        chk("close2_cost", min_cost, 8'h20);
        chk("close2_we_addr", wa, 3);
`else
        chk("two_no_write", wc, 0);
`endif

        // Tie goes to the lower address
        load_img(5, 8'h07, 12, 8'h07, 0, 8'h08);
        run_scan(0, 0, dc, nd, wc, wa, bok, hok);
        chk("tie_found", found, 1);
        chk("tie_addr", min_addr, 5);
        chk("tie_cost", min_cost, 8'h07);
        chk("tie_hold", hok, 1);

        // Extra start during a scan is ignored
        load_img(5, 8'h07, 12, 8'h07, 0, 8'h08);
        run_scan(5, 0, dc, nd, wc, wa, bok, hok);
        chk("xstart_ndone", nd, 1);
        chk("xstart_latency", dc, LAT);
        chk("xstart_busy", bok, 1);
        chk("xstart_addr", min_addr, 5);

        // Reset mid-scan aborts with no done, then a fresh scan completes
        load_img(3, 8'h20, 9, 8'h10, -1, 0);
        run_scan(0, 8, dc, nd, wc, wa, bok, hok);
        chk("abort_ndone", nd, 0);
        load_img(3, 8'h20, 9, 8'h10, -1, 0);
        run_scan(0, 0, dc, nd, wc, wa, bok, hok);
        chk("fresh_latency", dc, LAT);
        chk("fresh_found", found, 1);
        chk("fresh_addr", min_addr, 9);
        chk("fresh_cost", min_cost, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/min_cost_select.md
# min_cost_select

Open-set minimum selector for the A* search datapath. It sits directly downstream of the node-cost queue memory. On each `start` it sweeps every queue address, compares the returned costs, and reports the lowest-cost open node (address and cost) to the expansion controller. An all-ones cost word marks a closed or empty slot and is never selected.

## Interface
- `DATA_WIDTH`, 8, cost word width; all-ones is the INVALID sentinel.
- `ADDR_WIDTH`, 4, queue address width; N = 2^ADDR_WIDTH entries scanned.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a scan; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle pulse; results valid in that cycle.
- `found`  out  1  at least one non-INVALID entry was seen.
- `min_cost`  out  DATA_WIDTH  lowest cost; INVALID when `found`=0.
- `min_addr`  out  ADDR_WIDTH  address of `min_cost`; 0 when `found`=0.
- `mem_addr`  out  ADDR_WIDTH  drives the queue address input.
- `mem_data`  in  DATA_WIDTH  queue registered read data.
- `mem_we`  out  1  queue write enable; only ever high when CLOSE_ON_SELECT_EN is defined.
- `mem_wdata`  out  DATA_WIDTH  queue write data; constant INVALID.

## Operation
- States: IDLE, SCAN, DRAIN, CLOSE (CLOSE exists only with the macro), DONE.
- IDLE:
  - `mem_addr`=0, `mem_we`=0.
  - `start`=1 moves to SCAN, clears the running minimum to INVALID/0, and clears the running found flag.
- SCAN:
  - `mem_addr` steps 0,1,…,N-1, one address per cycle.
  - After N-1 the block goes to DRAIN.
  - The counter is ADDR_WIDTH+1 bits wide so it cannot wrap.
- Compare pipeline:
  - `mem_data` belongs to the address driven one cycle earlier. A delayed address copy is compared with it.
  - Update rule: update when `mem_data` != INVALID and `mem_data` < running minimum (strict less-than).
  - Ties therefore go to the lowest address.
  - Any non-INVALID entry sets the running found flag.
- DRAIN: one cycle that absorbs the last read (address N-1).
- CLOSE: one cycle.
  - If found: `mem_we`=1, `mem_addr`=selected address, `mem_wdata`=INVALID.
  - If not found: no write.
- DONE:
  - `done`=1 for one cycle.
  - `found`/`min_cost`/`min_addr` are loaded from the running values.
  - Then the block returns to IDLE.
- Result outputs hold their value from `done` until the next `done`. They do not change during a scan.
- `start` while busy is ignored and is not queued.
- The upstream queue writer must be held off while `busy`. Write-port arbitration is external to this block.

## Timing
- Reset values: `busy`=0, `done`=0, `found`=0, `min_cost`=0, `min_addr`=0, `mem_addr`=0, `mem_we`=0. State is IDLE.
- Reset asserted mid-scan aborts immediately to these values. No partial result is reported.
- Cycle numbering: `start` sampled at edge 0.
  - Cycles 1..N: `mem_addr`=0..N-1.
  - Cycle N+1: DRAIN.
  - Without the macro: `done` in cycle N+2 (N=16 gives cycle 18).
  - With the macro: CLOSE in cycle N+2 and `done` in cycle N+3.
- A new `start` is accepted in the cycle after `done`. Back-to-back scan period is N+3 cycles without the macro, N+4 with it.
- Assumed queue read latency is exactly one cycle: `mem_addr` registered at edge k, data presented during cycle k+1.

## Configuration
- `CLOSE_ON_SELECT_EN` defined:
  - The CLOSE state is compiled in.
  - The selected entry is overwritten with INVALID, so it leaves the open set.
  - Latency is N+3.
- Not defined:
  - No CLOSE state.
  - `mem_we` is tied 0 and the queue is read-only from this block.
  - Latency is N+2.

## Test plan
- All 16 entries 0xFF, `start` -> `done` in cycle 18, `found`=0, `min_cost`=0xFF, `min_addr`=0.
- addr3=0x20, addr9=0x10, rest 0xFF -> `found`=1, `min_addr`=9, `min_cost`=0x10.
- addr5=0x07, addr12=0x07, addr0=0x08 -> `min_addr`=5 (tie goes to the lower address).
- Extra `start` pulse in cycle 5 of a scan -> exactly one `done`, still in cycle 18; `busy` stays high throughout.
- `rst_n` low in cycle 8 of a scan -> all outputs 0 asynchronously, no `done`. A fresh `start` then completes normally.
- With `CLOSE_ON_SELECT_EN`, contents as in scenario 2:
  - First scan: `mem_we`=1 at addr 9 in cycle 18, `done` in cycle 19.
  - Second scan returns `min_addr`=3, `min_cost`=0x20.
